norflash_cmd_arbiter: RTL and testbench

- Two-port command arbiter and sequencer in front of the SPI NOR flash controller command interface.
- Shares the flash controller between two requesters: port 0 is the APB bridge, port 1 is the on-board test/driver logic.
- Arbitrates round-robin and validates commands.
- Drives the controller's one-cycle request strobe with registered command, address and data.
- Tracks the single outstanding operation to completion or timeout, then returns status and read data to the owning requester.

---
 rtl/norflash_cmd_arbiter_if.sv | 43 ++++
 rtl/norflash_cmd_arbiter.sv | 161 ++++++++++++++++
 tb/tb_norflash_cmd_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/norflash_cmd_arbiter_if.sv
// Command-side bundle of the NOR flash arbiter: two requester ports plus the
// flash controller strobe/command/completion signals.
interface norflash_cmd_arbiter_if #(
  parameter int unsigned ASIZE = 22,
  parameter int unsigned DSIZE = 8
);
  logic             req0_i;
  logic             req1_i;
  logic [2:0]       cmd0_i;
  logic [2:0]       cmd1_i;
  logic [ASIZE-1:0] addr0_i;
  logic [ASIZE-1:0] addr1_i;
  logic [DSIZE-1:0] wdata0_i;
  logic [DSIZE-1:0] wdata1_i;
  logic             gnt0_o;
  logic             gnt1_o;
  logic             done0_o;
  logic             done1_o;
  logic             err_o;
  logic [DSIZE-1:0] rdata_o;
  logic             busy_o;
  logic             flash_req_o;
  logic [2:0]       sys_cmd_o;
  logic [ASIZE-1:0] sys_rd_addr_o;
  logic [ASIZE-1:0] sys_wr_addr_o;
  logic [DSIZE-1:0] sys_wr_data_o;
  logic             flash_done_i;
  logic [DSIZE-1:0] flash_rdata_i;

  modport slave (
    input  req0_i, req1_i, cmd0_i, cmd1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    input  flash_done_i, flash_rdata_i,
    output gnt0_o, gnt1_o, done0_o, done1_o, err_o, rdata_o, busy_o,
    output flash_req_o, sys_cmd_o, sys_rd_addr_o, sys_wr_addr_o, sys_wr_data_o
  );

  modport master (
    output req0_i, req1_i, cmd0_i, cmd1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    output flash_done_i, flash_rdata_i,
    input  gnt0_o, gnt1_o, done0_o, done1_o, err_o, rdata_o, busy_o,
    input  flash_req_o, sys_cmd_o, sys_rd_addr_o, sys_wr_addr_o, sys_wr_data_o
  );
endinterface

// File: rtl/norflash_cmd_arbiter.sv
// Round-robin two-port arbiter and single-operation sequencer in front of the
// SPI NOR flash controller command interface.
module norflash_cmd_arbiter #(
  parameter int unsigned     ASIZE  = 22,
  parameter int unsigned     DSIZE  = 8,
  parameter int unsigned     TO_W   = 24,
  parameter logic [TO_W-1:0] TO_CYC = 24'd12_000_000
) (
  input logic                   sys_clk,
  input logic                   sys_rst,
  norflash_cmd_arbiter_if.slave bus
);

  localparam logic [2:0]      CmdRead  = 3'b000;
  localparam logic [2:0]      CmdWrite = 3'b001;
  localparam logic [2:0]      CmdErase = 3'b010;
  localparam logic [TO_W-1:0] CntOne   = TO_W'(1);
  localparam logic [TO_W-1:0] CntLast  = TO_CYC - CntOne;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           r_state;
  logic             r_last;
  logic             r_owner;
  logic [TO_W-1:0]  r_cnt;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic             r_err;
  logic [DSIZE-1:0] r_rdata;
  logic             r_flash_req;
  logic [2:0]       r_sys_cmd;
  logic [ASIZE-1:0] r_rd_addr;
  logic [ASIZE-1:0] r_wr_addr;
  logic [DSIZE-1:0] r_wr_data;

  logic             w_any;
  logic             w_pick1;
  logic [2:0]       w_cmd;
  logic [ASIZE-1:0] w_addr;
  logic [DSIZE-1:0] w_wdata;
  logic             w_valid;
  logic [ASIZE-1:0] w_erase_addr;

  // On a tie the port that did not win last time is served.
  assign w_any        = bus.req0_i | bus.req1_i;
  assign w_pick1      = bus.req1_i & (~bus.req0_i | ~r_last);
  assign w_cmd        = w_pick1 ? bus.cmd1_i   : bus.cmd0_i;
  assign w_addr       = w_pick1 ? bus.addr1_i  : bus.addr0_i;
  assign w_wdata      = w_pick1 ? bus.wdata1_i : bus.wdata0_i;
  assign w_valid      = (w_cmd == CmdRead) | (w_cmd == CmdWrite) | (w_cmd == CmdErase);
  assign w_erase_addr = {w_addr[ASIZE-1:13], 13'd0};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= StIdle;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_cnt       <= '0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_flash_req <= 1'b0;
      r_sys_cmd   <= '0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_owner <= w_pick1;
            r_last  <= w_pick1;
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
            if (w_valid) begin
              // sys_* are loaded here so they are already valid with the strobe.
              r_state     <= StIssue;
              r_flash_req <= 1'b1;
              r_sys_cmd   <= w_cmd;
              if (w_cmd == CmdRead) begin
                r_rd_addr <= w_addr;
              end else if (w_cmd == CmdWrite) begin
                r_wr_addr <= w_addr;
                r_wr_data <= w_wdata;
              end else begin
                r_wr_addr <= w_erase_addr;
              end
            end else begin
              r_state <= StResp;
            end
          end
        end

        StIssue: begin
          r_gnt0      <= 1'b0;
          r_gnt1      <= 1'b0;
          r_flash_req <= 1'b0;
          r_cnt       <= '0;
          r_state     <= StWait;
        end

        StWait: begin
          if (bus.flash_done_i) begin
            r_state <= StResp;
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_err   <= 1'b0;
            r_rdata <= (r_sys_cmd == CmdRead) ? bus.flash_rdata_i : '0;
          end else if (r_cnt == CntLast) begin
            r_state <= StResp;
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end

        StResp: begin
          if (r_done0 | r_done1) begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_state <= StIdle;
          end else begin
            // Invalid-command path: grant cycle first, error completion next.
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.gnt0_o        = r_gnt0;
  assign bus.gnt1_o        = r_gnt1;
  assign bus.done0_o       = r_done0;
  assign bus.done1_o       = r_done1;
  assign bus.err_o         = r_err;
  assign bus.rdata_o       = r_rdata;
  assign bus.busy_o        = (r_state != StIdle);
  assign bus.flash_req_o   = r_flash_req;
  assign bus.sys_cmd_o     = r_sys_cmd;
  assign bus.sys_rd_addr_o = r_rd_addr;
  assign bus.sys_wr_addr_o = r_wr_addr;
  assign bus.sys_wr_data_o = r_wr_data;

endmodule

// File: tb/tb_norflash_cmd_arbiter.sv
// Scoreboard bench for norflash_cmd_arbiter: transaction-level model pushes
// expected grants, flash strobes and completions; a monitor pops and compares.
module tb_norflash_cmd_arbiter;
  localparam int unsigned ASIZE = 22;
  localparam int unsigned DSIZE = 8;
  localparam int          TO    = 16;

  typedef struct {
    logic [2:0]  cmd;
    logic [21:0] addr;
    logic [7:0]  wdata;
    int          d;      // flash latency in cycles after the strobe, 0 = never
    logic [7:0]  fdata;
  } op_t;
  typedef struct {
    logic [2:0]  cmd;
    logic [21:0] rd;
    logic [21:0] wr;
    logic [7:0]  wd;
  } issue_t;
  typedef struct {
    int         port;
    logic       err;
    logic [7:0] rdata;
    int         lat;
  } done_t;
  typedef struct {
    int         d;
    logic [7:0] data;
  } fplan_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  norflash_cmd_arbiter_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) bus ();

  norflash_cmd_arbiter #(
    .ASIZE (ASIZE),
    .DSIZE (DSIZE),
    .TO_W  (24),
    .TO_CYC(24'd16)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus    (bus)
  );

  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     q_gnt[$];
  issue_t q_issue[$];
  done_t  q_done[$];
  fplan_t q_fplan[$];
  int     stray_cnt = 0;
  int     stray_seen = 0;

  // Reference model state
  int          m_last;
  logic [2:0]  m_cmd;
  logic [21:0] m_rd;
  logic [21:0] m_wr;
  logic [7:0]  m_wd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event seen, none expected (cycle %0d)", name, cyc);
  endtask

  task automatic reset_model();
    m_last = 1;
    m_cmd  = '0;
    m_rd   = '0;
    m_wr   = '0;
    m_wd   = '0;
    q_gnt.delete();
    q_issue.delete();
    q_done.delete();
    q_fplan.delete();
  endtask

  // Monitor
  int     mp;
  int     gnt_cyc[2];
  issue_t mi;
  done_t  md;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.gnt0_o || bus.gnt1_o) begin
        if (q_gnt.size() == 0) unexpected("gnt");
        else begin
          mp = q_gnt.pop_front();
          check("gnt_port", 64'(bus.gnt1_o), 64'(mp == 1));
          check("gnt_onehot", 64'(bus.gnt0_o & bus.gnt1_o), 64'd0);
          gnt_cyc[mp] = cyc;
        end
      end
      if (bus.flash_req_o) begin
        if (q_issue.size() == 0) unexpected("flash_req");
        else begin
          mi = q_issue.pop_front();
          check("sys_cmd", 64'(bus.sys_cmd_o), 64'(mi.cmd));
          check("sys_rd_addr", 64'(bus.sys_rd_addr_o), 64'(mi.rd));
          check("sys_wr_addr", 64'(bus.sys_wr_addr_o), 64'(mi.wr));
          check("sys_wr_data", 64'(bus.sys_wr_data_o), 64'(mi.wd));
        end
      end
      if (bus.done0_o || bus.done1_o) begin
        if (q_done.size() == 0) unexpected("done");
        else begin
          md = q_done.pop_front();
          check("done_port", 64'(bus.done1_o), 64'(md.port == 1));
          check("done_onehot", 64'(bus.done0_o & bus.done1_o), 64'd0);
          check("err", 64'(bus.err_o), 64'(md.err));
          check("rdata", 64'(bus.rdata_o), 64'(md.rdata));
          check("latency", 64'(cyc - gnt_cyc[md.port]), 64'(md.lat));
          check("busy_at_done", 64'(bus.busy_o), 64'd1);
        end
      end
    end
  end

  // Flash controller model
  fplan_t fp;
  initial begin
    bus.flash_done_i  = 1'b0;
    bus.flash_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        bus.flash_done_i  = 1'b1;
        bus.flash_rdata_i = 8'h77;
        @(posedge clk);
        #1;
        bus.flash_done_i = 1'b0;
      end else if (bus.flash_req_o && !rst) begin
        fp = (q_fplan.size() != 0) ? q_fplan.pop_front() : '{d: 0, data: 8'h00};
        if (fp.d != 0) begin
          repeat (fp.d) @(posedge clk);
          #1;
          bus.flash_done_i  = 1'b1;
          bus.flash_rdata_i = fp.data;
          @(posedge clk);
          #1;
          bus.flash_done_i  = 1'b0;
          bus.flash_rdata_i = $urandom_range(0, 255);
        end
      end
    end
  end

  task automatic expect_op(input int p, input op_t o);
    issue_t it;
    done_t  dn;
    bit     tout;
    m_last = p;
    q_gnt.push_back(p);
    if (o.cmd <= 3'd2) begin
      m_cmd = o.cmd;
      if (o.cmd == 3'd0) m_rd = o.addr;
      else if (o.cmd == 3'd1) begin
        m_wr = o.addr;
        m_wd = o.wdata;
      end else m_wr = 22'((int'(o.addr) / 8192) * 8192);
      it = '{cmd: m_cmd, rd: m_rd, wr: m_wr, wd: m_wd};
      q_issue.push_back(it);
      q_fplan.push_back('{d: o.d, data: o.fdata});
      tout = (o.d == 0) || (o.d > TO);
      dn.port  = p;
      dn.err   = tout;
      dn.rdata = (!tout && o.cmd == 3'd0) ? o.fdata : 8'h00;
      dn.lat   = tout ? TO + 1 : o.d + 1;
    end else begin
      dn = '{port: p, err: 1'b1, rdata: 8'h00, lat: 1};
    end
    q_done.push_back(dn);
  endtask

  task automatic run_group(input bit u0, input bit u1, input op_t o0, input op_t o1);
    int  first;
    bit  ok;
    if (u0 && u1) begin
      first = 1 - m_last;
      expect_op(first, first ? o1 : o0);
      expect_op(1 - first, first ? o0 : o1);
    end else if (u1) expect_op(1, o1);
    else expect_op(0, o0);
    @(posedge clk);
    #1;
    bus.req0_i   = u0;
    bus.cmd0_i   = o0.cmd;
    bus.addr0_i  = o0.addr;
    bus.wdata0_i = o0.wdata;
    bus.req1_i   = u1;
    bus.cmd1_i   = o1.cmd;
    bus.addr1_i  = o1.addr;
    bus.wdata1_i = o1.wdata;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.gnt0_o) bus.req0_i = 1'b0;
      if (bus.gnt1_o) bus.req1_i = 1'b0;
      if (!bus.req0_i && !bus.req1_i && q_done.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      unexpected("completion_timeout");
      bus.req0_i = 1'b0;
      bus.req1_i = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      reset_model();
    end else begin
      check("idle_busy", 64'(bus.busy_o), 64'd0);
      check("idle_err", 64'(bus.err_o), 64'd0);
      check("idle_rdata", 64'(bus.rdata_o), 64'd0);
    end
  endtask

  function automatic op_t mk(input logic [2:0] c, input logic [21:0] a, input logic [7:0] w,
                             input int d, input logic [7:0] f);
    op_t o;
    o = '{cmd: c, addr: a, wdata: w, d: d, fdata: f};
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  s;
    o.cmd   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    o.addr  = 22'($urandom);
    o.wdata = 8'($urandom);
    o.fdata = 8'($urandom);
    s = $urandom_range(0, 9);
    o.d = (s == 0) ? 0 : (s == 1) ? TO : $urandom_range(1, TO - 1);
    return o;
  endfunction

  op_t nop;
  op_t a;
  op_t b;
  initial begin
    nop = mk(3'd0, 22'd0, 8'd0, 1, 8'd0);
    bus.req0_i = 1'b0; bus.cmd0_i = '0; bus.addr0_i = '0; bus.wdata0_i = '0;
    bus.req1_i = 1'b0; bus.cmd1_i = '0; bus.addr1_i = '0; bus.wdata1_i = '0;
    reset_model();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt0", 64'(bus.gnt0_o), 64'd0);
    check("rst_gnt1", 64'(bus.gnt1_o), 64'd0);
    check("rst_done0", 64'(bus.done0_o), 64'd0);
    check("rst_done1", 64'(bus.done1_o), 64'd0);
    check("rst_err", 64'(bus.err_o), 64'd0);
    check("rst_rdata", 64'(bus.rdata_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_flash_req", 64'(bus.flash_req_o), 64'd0);
    check("rst_sys_cmd", 64'(bus.sys_cmd_o), 64'd0);
    check("rst_sys_rd", 64'(bus.sys_rd_addr_o), 64'd0);
    check("rst_sys_wr", 64'(bus.sys_wr_addr_o), 64'd0);
    check("rst_sys_wd", 64'(bus.sys_wr_data_o), 64'd0);
    rst = 1'b0;

    // Read with flash completion four cycles after the strobe.
    run_group(1, 0, mk(3'd0, 22'h002000, 8'h00, 4, 8'hCC), nop);
    // Three simultaneous request pairs.
    for (int i = 0; i < 3; i++)
      run_group(1, 1, mk(3'd0, 22'(24'h100 + i), 8'h10, 2, 8'(i)),
                mk(3'd1, 22'(24'h200 + i), 8'h20, 3, 8'h00));
    run_group(1, 0, mk(3'd2, 22'h003ABC, 8'hEE, 3, 8'h00), nop);
    run_group(0, 1, nop, mk(3'd1, 22'h001234, 8'h5A, 2, 8'h00));
    run_group(0, 1, nop, mk(3'b101, 22'h000055, 8'h11, 1, 8'h00));
    run_group(1, 0, mk(3'd0, 22'h000777, 8'h00, 0, 8'h99), nop);
    run_group(1, 0, mk(3'd0, 22'h000888, 8'h00, TO, 8'h3C), nop);

    // Reset while waiting on the flash.
    q_gnt.push_back(0);
    m_rd = 22'h000999;
    m_cmd = 3'd0;
    q_issue.push_back('{cmd: m_cmd, rd: m_rd, wr: m_wr, wd: m_wd});
    q_fplan.push_back('{d: 0, data: 8'h00});
    @(posedge clk);
    #1;
    bus.req0_i = 1'b1; bus.cmd0_i = 3'd0; bus.addr0_i = 22'h000999;
    for (int i = 0; i < 5 && bus.req0_i; i++) begin
      @(posedge clk);
      #1;
      if (bus.gnt0_o) bus.req0_i = 1'b0;
    end
    if (bus.req0_i) begin
      unexpected("gnt_before_reset");
      bus.req0_i = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    check("busy_in_wait", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(bus.busy_o), 64'd0);
    check("midrst_sys_cmd", 64'(bus.sys_cmd_o), 64'd0);
    check("midrst_sys_rd", 64'(bus.sys_rd_addr_o), 64'd0);
    check("midrst_done0", 64'(bus.done0_o), 64'd0);
    check("midrst_err", 64'(bus.err_o), 64'd0);
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    stray_cnt++;
    repeat (6) @(posedge clk);
    check("stray_busy", 64'(bus.busy_o), 64'd0);
    run_group(1, 0, mk(3'd0, 22'h000ABC, 8'h00, 5, 8'hA5), nop);

    for (int i = 0; i < 60; i++) begin
      a = rand_op();
      b = rand_op();
      case ($urandom_range(0, 2))
        0:       run_group(1, 0, a, b);
        1:       run_group(0, 1, a, b);
        default: run_group(1, 1, a, b);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
